mac_decoder_lanes: RTL and testbench

MAC_DECODER_LANES -- requirements
Module: mac_decoder_lanes

---
 rtl/mac_decoder_lanes_pkg.sv | 16 +
 rtl/mac_decoder_lanes.sv | 206 ++++++++++++++++++++
 tb/tb_mac_decoder_lanes.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_decoder_lanes_pkg.sv
// ----------------------------------------------------------------------------
// mac_decoder_lanes_pkg
// Shared types for the MAC operand lane decoder.
//   mac_datatype : beat format selector. FP16 and FP8 are named; every other
//                  encoding (MAC_DATATYPE_INT9 or the unused code 2'd3) is
//                  decoded as 9-bit signed integer.
// ----------------------------------------------------------------------------
package mac_decoder_lanes_pkg;

    typedef enum logic [1:0] {
        MAC_DATATYPE_FP16 = 2'd0,
        MAC_DATATYPE_FP8  = 2'd1,
        MAC_DATATYPE_INT9 = 2'd2
    } mac_datatype;

endpackage

// File: rtl/mac_decoder_lanes.sv
// ----------------------------------------------------------------------------
// mac_decoder_lanes
// Decodes LANES packed 16-bit operands per beat into zero/sign/exponent/
// mantissa fields (FP16, FP8 or INT9), buffers decoded beats in a 2-entry
// FIFO and keeps a saturating count of zero lanes seen on accepted beats.
//
// Build option:
//   MAC_DECODER_FTZ_EN  when defined, FP16/FP8 subnormals flush to zero
//                       (zero=1, exp=0, mant=0, sign kept) and are counted
//                       as zero lanes. Undefined: subnormals decode normally.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_valid / o_ready      input beat handshake
//   i_datatype, i_data     beat format and packed lanes (lane k = [16k+15:16k])
//   o_valid / i_ready      output beat handshake
//   o_datatype             format captured with the head beat
//   o_iszero, o_sign       per-lane flags of the head beat
//   o_exp, o_mant          per-lane 5-bit exponent / 11-bit mantissa
//   o_all_zero             every lane of the head beat is zero
//   i_cnt_clr, o_zero_cnt  clear / value of the saturating zero-lane counter
// ----------------------------------------------------------------------------
module mac_decoder_lanes
    import mac_decoder_lanes_pkg::*;
#(
    parameter int LANES = 8,
    parameter int CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  mac_datatype           i_datatype,
    input  logic [LANES*16-1:0]   i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output mac_datatype           o_datatype,
    output logic [LANES-1:0]      o_iszero,
    output logic [LANES-1:0]      o_sign,
    output logic [LANES*5-1:0]    o_exp,
    output logic [LANES*11-1:0]   o_mant,
    output logic                  o_all_zero,
    input  logic                  i_cnt_clr,
    output logic [CNT_W-1:0]      o_zero_cnt
);

    localparam int PC_W = $clog2(LANES + 1);

    typedef struct packed {
        mac_datatype             dt;
        logic [LANES-1:0]        iszero;
        logic [LANES-1:0]        sign;
        logic [LANES*5-1:0]      expo;
        logic [LANES*11-1:0]     mant;
    } beat_t;

    // Decode one lane; result packed as {zero, sign, exp[4:0], mant[10:0]}.
    function automatic logic [17:0] decode_lane(input mac_datatype dt, input logic [15:0] d);
        logic       sub;
        logic       zero;
        logic       sign;
        logic [4:0] expo;
        logic [10:0] mant;
        sub  = 1'b0;
        zero = 1'b0;
        sign = 1'b0;
        expo = 5'd0;
        mant = 11'd0;
        case (dt)
            MAC_DATATYPE_FP16: begin
                sub  = (d[14:10] == 5'd0) && (d[9:0] != 10'd0);
                sign = d[15];
                expo = d[14:10];
                mant = {sub, d[9:0]};
                zero = (d == 16'd0);
            end
            MAC_DATATYPE_FP8: begin
                sub  = (d[6:3] == 4'd0) && (d[2:0] != 3'd0);
                sign = d[7];
                expo = {1'b0, d[6:3]};
                mant = {7'd0, sub, d[2:0]};
                zero = (d[7:0] == 8'd0);
            end
            default: begin
                // Any non-float code is a 9-bit signed integer.
                sign = d[8];
                expo = 5'd0;
                mant = {2'd0, d[8:0]};
                zero = (d[8:0] == 9'd0);
            end
        endcase
`ifdef MAC_DECODER_FTZ_EN
        // Flush subnormals to a signed zero.
        if (sub) begin
            zero = 1'b1;
            expo = 5'd0;
            mant = 11'd0;
        end else begin
            zero = zero;
        end
`endif
        return {zero, sign, expo, mant};
    endfunction

    beat_t              head_q, head_d;
    beat_t              tail_q, tail_d;
    logic [1:0]         count_q, count_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    beat_t              new_beat_s;
    logic [17:0]        lane_dec_s;
    logic [PC_W-1:0]    new_zeros_s;
    logic [CNT_W:0]     cnt_sum_s;
    logic               push_s;
    logic               pop_s;

    // Decode all lanes of the incoming beat and count its zero lanes.
    always_comb begin
        new_beat_s    = '0;
        lane_dec_s    = 18'd0;
        new_zeros_s   = '0;
        new_beat_s.dt = i_datatype;
        for (int k = 0; k < LANES; k++) begin
            lane_dec_s                  = decode_lane(i_datatype, i_data[16*k +: 16]);
            new_beat_s.iszero[k]        = lane_dec_s[17];
            new_beat_s.sign[k]          = lane_dec_s[16];
            new_beat_s.expo[5*k +: 5]   = lane_dec_s[15:11];
            new_beat_s.mant[11*k +: 11] = lane_dec_s[10:0];
            new_zeros_s                 = new_zeros_s + PC_W'(lane_dec_s[17]);
        end
    end

    // FIFO next state: head is always the oldest beat, tail the second one.
    always_comb begin
        push_s  = i_valid && ready_q;
        pop_s   = (count_q != 2'd0) && i_ready;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = new_beat_s;
                end else begin
                    tail_d = new_beat_s;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push only happens below count 2, pop only above 0: count is 1,
                // so the new beat replaces the departing head directly.
                head_d = new_beat_s;
            end
            default: begin
                count_d = count_q;
            end
        endcase
        // Readiness is a flop so i_ready never reaches o_ready combinationally.
        ready_d = (count_d < 2'd2);
    end

    // Saturating zero-lane counter; clear wins over a same-cycle increment.
    always_comb begin
        cnt_sum_s = {1'b0, cnt_q} + {{(CNT_W + 1 - PC_W){1'b0}}, new_zeros_s};
        if (i_cnt_clr) begin
            cnt_d = '0;
        end else if (push_s) begin
            cnt_d = cnt_sum_s[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset that also drops buffered beats.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid    = (count_q != 2'd0);
    assign o_ready    = ready_q;
    assign o_datatype = head_q.dt;
    assign o_iszero   = head_q.iszero;
    assign o_sign     = head_q.sign;
    assign o_exp      = head_q.expo;
    assign o_mant     = head_q.mant;
    assign o_all_zero = &head_q.iszero;
    assign o_zero_cnt = cnt_q;

endmodule

// File: tb/tb_mac_decoder_lanes.sv
// ----------------------------------------------------------------------------
// tb_mac_decoder_lanes
// Self-checking bench: a queue-based reference model of the decoder FIFO and
// zero counter checked every cycle, plus literal checks of known decodes,
// backpressure ordering, counter clear and mid-stream reset.
// ----------------------------------------------------------------------------
module tb_mac_decoder_lanes;
    import mac_decoder_lanes_pkg::*;

    localparam int LANES   = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic                 i_valid;
    logic                 o_ready;
    mac_datatype          i_datatype;
    logic [LANES*16-1:0]  i_data;
    logic                 o_valid;
    logic                 i_ready;
    mac_datatype          o_datatype;
    logic [LANES-1:0]     o_iszero;
    logic [LANES-1:0]     o_sign;
    logic [LANES*5-1:0]   o_exp;
    logic [LANES*11-1:0]  o_mant;
    logic                 o_all_zero;
    logic                 i_cnt_clr;
    logic [CNT_W-1:0]     o_zero_cnt;

    always #5 clk = ~clk;

    mac_decoder_lanes #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_datatype (i_datatype),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_datatype (o_datatype),
        .o_iszero   (o_iszero),
        .o_sign     (o_sign),
        .o_exp      (o_exp),
        .o_mant     (o_mant),
        .o_all_zero (o_all_zero),
        .i_cnt_clr  (i_cnt_clr),
        .o_zero_cnt (o_zero_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]          dt;
        logic [LANES-1:0]    z;
        logic [LANES-1:0]    s;
        logic [LANES*5-1:0]  e;
        logic [LANES*11-1:0] m;
    } exp_beat_t;

    exp_beat_t mq[$];
    int        m_cnt     = 0;
    bit        m_ready   = 1'b0;
    bit        m_started = 1'b0;
    bit        m_cleared = 1'b0;
    bit        m_acc;
    bit        m_pop;
    exp_beat_t m_nb;

    function automatic exp_beat_t model_beat(input logic [1:0] dt, input logic [LANES*16-1:0] data);
        exp_beat_t b;
        int d, e, m;
        bit z, s, sub;
        b = '0;
        b.dt = dt;
        for (int k = 0; k < LANES; k++) begin
            d = int'(data[16*k +: 16]);
            if (dt == 2'd0) begin
                e = (d >> 10) & 31; m = d & 1023; s = bit'((d >> 15) & 1); z = (d == 0);
                sub = (e == 0) && (m != 0);
                if (sub) begin
`ifdef MAC_DECODER_FTZ_EN
                    z = 1'b1; m = 0;
`else
                    m = m + 1024;
`endif
                end
            end else if (dt == 2'd1) begin
                e = (d >> 3) & 15; m = d & 7; s = bit'((d >> 7) & 1); z = ((d & 255) == 0);
                sub = (e == 0) && (m != 0);
                if (sub) begin
`ifdef MAC_DECODER_FTZ_EN
                    z = 1'b1; m = 0;
`else
                    m = m + 8;
`endif
                end
            end else begin
                e = 0; m = d & 511; s = bit'((m >> 8) & 1); z = (m == 0);
            end
            b.z[k]          = z;
            b.s[k]          = s;
            b.e[5*k +: 5]   = 5'(e);
            b.m[11*k +: 11] = 11'(m);
        end
        return b;
    endfunction

    // Model update on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (i_reset) begin
            mq.delete();
            m_cnt     = 0;
            m_ready   = 1'b0;
            m_started = 1'b1;
            m_cleared = 1'b1;
        end else if (m_started) begin
            m_acc = i_valid && m_ready;
            m_pop = (mq.size() != 0) && i_ready;
            m_nb  = model_beat(2'(i_datatype), i_data);
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                mq.push_back(m_nb);
                m_cleared = 1'b0;
            end
            if (i_cnt_clr) m_cnt = 0;
            else if (m_acc) begin
                m_cnt = m_cnt + $countones(m_nb.z);
                if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
            end
            m_ready = (mq.size() < 2);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("cmp_valid", 128'(o_valid), 128'(mq.size() != 0));
            check("cmp_ready", 128'(o_ready), 128'(m_ready));
            check("cmp_cnt", 128'(o_zero_cnt), 128'(m_cnt));
            if (m_cleared) begin
                check("cmp_rst_payload", {o_iszero, o_sign, o_exp, o_mant}, 128'd0);
            end
            if (mq.size() != 0) begin
                check("cmp_dt", 128'(2'(o_datatype)), 128'(mq[0].dt));
                check("cmp_iszero", 128'(o_iszero), 128'(mq[0].z));
                check("cmp_sign", 128'(o_sign), 128'(mq[0].s));
                check("cmp_exp", 128'(o_exp), 128'(mq[0].e));
                check("cmp_mant", 128'(o_mant), 128'(mq[0].m));
                check("cmp_all_zero", 128'(o_all_zero), 128'(&mq[0].z));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_one(input mac_datatype dt, input logic [LANES*16-1:0] data);
        i_valid    = 1'b1;
        i_ready    = 1'b1;
        i_datatype = dt;
        i_data     = data;
        step();
        i_valid    = 1'b0;
    endtask

    logic [LANES*16-1:0] dv;
    logic [CNT_W-1:0]    cnt0;
    logic [LANES*11-1:0] held_mant;
    logic [8:0]          got[$];
    int                  nxt;
    bit                  rdy_now;
    int                  sel;

    initial begin
        i_reset    = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_datatype = MAC_DATATYPE_FP16;
        i_data     = '0;
        i_cnt_clr  = 1'b0;
        step();
        step();
        check("rst_valid", 128'(o_valid), 128'd0);
        check("rst_ready", 128'(o_ready), 128'd0);
        check("rst_cnt", 128'(o_zero_cnt), 128'd0);
        check("rst_mant", 128'(o_mant), 128'd0);
        i_reset = 1'b0;
        step();
        check("ready_after_rst", 128'(o_ready), 128'd1);

        // FP16 1.0 in lane 0, latency 1
        dv = {LANES{16'h4000}};
        dv[15:0] = 16'h3C00;
        send_one(MAC_DATATYPE_FP16, dv);
        check("fp16_one_valid", 128'(o_valid), 128'd1);
        check("fp16_one_sign", 128'(o_sign[0]), 128'd0);
        check("fp16_one_exp", 128'(o_exp[4:0]), 128'h0F);
        check("fp16_one_mant", 128'(o_mant[10:0]), 128'h000);
        check("fp16_one_zero", 128'(o_iszero[0]), 128'd0);

        // FP16 smallest subnormal
        cnt0 = o_zero_cnt;
        dv = {LANES{16'h3C00}};
        dv[15:0] = 16'h0001;
        send_one(MAC_DATATYPE_FP16, dv);
        check("fp16_sub_exp", 128'(o_exp[4:0]), 128'd0);
`ifdef MAC_DECODER_FTZ_EN
        check("fp16_sub_zero", 128'(o_iszero[0]), 128'd1);
        check("fp16_sub_mant", 128'(o_mant[10:0]), 128'd0);
        check("fp16_sub_cnt", 128'(o_zero_cnt), 128'(cnt0 + 8'd1));
`else
        check("fp16_sub_zero", 128'(o_iszero[0]), 128'd0);
        check("fp16_sub_mant", 128'(o_mant[10:0]), 128'h401);
        check("fp16_sub_cnt", 128'(o_zero_cnt), 128'(cnt0));
`endif

        // FP8 and INT9 negatives
        dv = {LANES{16'h0088}};
        send_one(MAC_DATATYPE_FP8, dv);
        check("fp8_sign", 128'(o_sign[0]), 128'd1);
        check("fp8_exp", 128'(o_exp[4:0]), 128'h01);
        check("fp8_mant", 128'(o_mant[10:0]), 128'h000);
        dv = {LANES{16'h01FF}};
        send_one(MAC_DATATYPE_INT9, dv);
        check("int9_sign", 128'(o_sign[0]), 128'd1);
        check("int9_exp", 128'(o_exp[4:0]), 128'd0);
        check("int9_mant", 128'(o_mant[10:0]), 128'h1FF);
        step();

        // Backpressure: 5 stalled cycles, then drain in order
        i_ready    = 1'b0;
        i_valid    = 1'b1;
        i_datatype = MAC_DATATYPE_INT9;
        nxt        = 1;
        held_mant  = '0;
        for (int c = 0; c < 5; c++) begin
            dv = '0;
            dv[8:0] = 9'(nxt);
            i_data  = dv;
            rdy_now = o_ready;
            step();
            if (rdy_now) nxt++;
            if (c == 0) held_mant = o_mant;
            else check("stall_stable", 128'(o_mant), 128'(held_mant));
        end
        check("stall_ready_low", 128'(o_ready), 128'd0);
        check("stall_accepts", 128'(nxt), 128'd3);
        i_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            if (nxt > 5) begin
                i_valid = 1'b0;
            end else begin
                dv = '0;
                dv[8:0] = 9'(nxt);
                i_data  = dv;
                i_valid = 1'b1;
            end
            if (o_valid) got.push_back(o_mant[8:0]);
            rdy_now = o_ready;
            step();
            if (rdy_now && i_valid) nxt++;
        end
        i_valid = 1'b0;
        check("drain_count", 128'(got.size()), 128'd5);
        for (int i = 0; i < got.size(); i++) begin
            check("drain_order", 128'(got[i]), 128'(i + 1));
        end
        step();

        // Zero-lane counting and clear priority
        i_cnt_clr = 1'b1;
        step();
        i_cnt_clr = 1'b0;
        check("clr_cnt", 128'(o_zero_cnt), 128'd0);
        i_valid    = 1'b1;
        i_ready    = 1'b1;
        i_datatype = MAC_DATATYPE_FP16;
        i_data     = '0;
        step(); step(); step();
        check("zero_all", 128'(o_all_zero), 128'd1);
        check("zero_cnt24", 128'(o_zero_cnt), 128'd24);
        i_cnt_clr = 1'b1;
        step();
        i_cnt_clr = 1'b0;
        i_valid   = 1'b0;
        check("clr_priority", 128'(o_zero_cnt), 128'd0);
        step();

        // Reset with a full FIFO
        i_ready    = 1'b0;
        i_valid    = 1'b1;
        i_datatype = MAC_DATATYPE_INT9;
        i_data     = '0;
        step(); step();
        check("full_valid", 128'(o_valid), 128'd1);
        check("full_ready", 128'(o_ready), 128'd0);
        check("full_cnt", 128'(o_zero_cnt), 128'd16);
        i_reset = 1'b1;
        step();
        check("midrst_valid", 128'(o_valid), 128'd0);
        check("midrst_cnt", 128'(o_zero_cnt), 128'd0);
        i_reset = 1'b0;
        i_valid = 1'b0;
        step();
        check("midrst_ready", 128'(o_ready), 128'd1);
        check("midrst_empty", 128'(o_valid), 128'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            i_valid    = ($urandom_range(0, 3) != 0);
            i_ready    = ($urandom_range(0, 2) != 0);
            i_datatype = mac_datatype'(2'($urandom_range(0, 3)));
            for (int k = 0; k < LANES; k++) begin
                sel = int'($urandom_range(0, 5));
                case (sel)
                    0: dv[16*k +: 16] = 16'h0000;
                    1: dv[16*k +: 16] = 16'($urandom_range(0, 7));
                    2: dv[16*k +: 16] = 16'h8000;
                    3: dv[16*k +: 16] = 16'($urandom_range(0, 1023));
                    default: dv[16*k +: 16] = 16'($urandom);
                endcase
            end
            i_data    = dv;
            i_cnt_clr = ($urandom_range(0, 63) == 0);
            i_reset   = ($urandom_range(0, 499) == 0);
            step();
        end
        i_reset   = 1'b0;
        i_valid   = 1'b0;
        i_cnt_clr = 1'b0;
        i_ready   = 1'b1;
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
